cb_mem_slave: RTL and testbench

Core-bus responder: the memory end of the channels the load/store unit and fetch path initiate on. Terminates s_cb_mosi_t, drives s_cb_miso_t and backs them with a word-organised, byte-strobed on-chip memory. Serves as the data/instruction RAM in simulation tops and FPGA builds. Independent read and write paths, one outstanding read, single-entry address and data buffers on the write side.

---
 rtl/utils_pkg.sv | 49 ++++
 rtl/cb_mem_array.sv | 46 ++++
 rtl/cb_mem_slave.sv | 113 +++++++++++
 tb/tb_cb_mem_slave.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared core-bus channel types, response codes and cb_mem_slave helpers.
package utils_pkg;

    typedef logic [3:0] cb_strb_t;

    typedef enum logic [1:0] {
        CB_OKAY   = 2'b00,
        CB_EXOKAY = 2'b01,
        CB_SLVERR = 2'b10,
        CB_DECERR = 2'b11
    } cb_resp_e;

    typedef struct packed {
        logic [31:0] rd_addr;
        logic [1:0]  rd_size;
        logic        rd_addr_valid;
        logic        rd_ready;
        logic [31:0] wr_addr;
        logic [1:0]  wr_size;
        logic        wr_addr_valid;
        logic [31:0] wr_data;
        cb_strb_t    wr_strobe;
        logic        wr_data_valid;
        logic        wr_resp_ready;
    } s_cb_mosi_t;

    typedef struct packed {
        logic        rd_addr_ready;
        logic [31:0] rd_data;
        logic        rd_valid;
        cb_resp_e    rd_resp;
        logic        wr_addr_ready;
        logic        wr_data_ready;
        logic        wr_resp_valid;
        cb_resp_e    wr_resp_error;
    } s_cb_miso_t;

    // Write-side buffer entry; addr and data/strobe halves fill independently.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        cb_strb_t    strobe;
    } cb_wr_entry_t;

    function automatic int unsigned cb_mem_idx_w(input int unsigned words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/cb_mem_array.sv
// 1R1W word memory with per-byte write enables and a registered read port that
// forwards a same-edge write to the same word (write-first).
module cb_mem_array
    import utils_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    localparam int unsigned IDX_W = cb_mem_idx_w(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  cb_strb_t         wstrb
);

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] merged;

    always_comb begin
        merged = mem[ridx];
        if (we && (widx == ridx)) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Only the read data register is reset; the array itself is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= merged;
    end

endmodule

// File: rtl/cb_mem_slave.sv
// Core-bus memory responder. Define CB_MEM_ADDR_ERR_EN to answer out-of-window
// addresses with CB_SLVERR; otherwise addresses wrap modulo MEM_WORDS.
module cb_mem_slave
    import utils_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  s_cb_mosi_t cb_mosi_i,
    output s_cb_miso_t cb_miso_o
);

    localparam int unsigned IDX_W = cb_mem_idx_w(MEM_WORDS);
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

    logic         rd_valid_ff, rd_err_ff;
    logic         aw_full_ff, w_full_ff;
    logic         wr_resp_valid_ff;
    cb_resp_e     wr_resp_err_ff;
    cb_wr_entry_t wbuf_ff;

    logic         rd_addr_ready, rd_hs, aw_hs, w_hs, commit, we;
    logic         rd_err, wr_err;
    logic [31:0]  rd_off, wr_off, cur_addr, cur_data, arr_rdata;
    cb_strb_t     cur_strb;
    logic         unused_bits;

    always_comb begin
        rd_addr_ready = ~rd_valid_ff | cb_mosi_i.rd_ready;
        rd_hs         = cb_mosi_i.rd_addr_valid & rd_addr_ready;
        aw_hs         = cb_mosi_i.wr_addr_valid & ~aw_full_ff;
        w_hs          = cb_mosi_i.wr_data_valid & ~w_full_ff;
        cur_addr      = aw_full_ff ? wbuf_ff.addr   : cb_mosi_i.wr_addr;
        cur_data      = w_full_ff  ? wbuf_ff.data   : cb_mosi_i.wr_data;
        cur_strb      = w_full_ff  ? wbuf_ff.strobe : cb_mosi_i.wr_strobe;
        rd_off        = cb_mosi_i.rd_addr - BASE_ADDR;
        wr_off        = cur_addr - BASE_ADDR;
        commit        = (aw_full_ff | aw_hs) & (w_full_ff | w_hs)
                      & (~wr_resp_valid_ff | cb_mosi_i.wr_resp_ready);
        we            = commit & ~wr_err;
    end

`ifdef CB_MEM_ADDR_ERR_EN
    assign rd_err = {1'b0, rd_off} >= SPAN;
    assign wr_err = {1'b0, wr_off} >= SPAN;
`else
    assign rd_err = 1'b0;
    assign wr_err = 1'b0;
`endif

    // Size fields and address bits above the index are intentionally ignored.
    assign unused_bits = ^{cb_mosi_i.rd_size, cb_mosi_i.wr_size, rd_off, wr_off, SPAN};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_ff      <= 1'b0;
            rd_err_ff        <= 1'b0;
            aw_full_ff       <= 1'b0;
            w_full_ff        <= 1'b0;
            wr_resp_valid_ff <= 1'b0;
            wr_resp_err_ff   <= CB_OKAY;
            wbuf_ff          <= '0;
        end else begin
            if (rd_hs) begin
                rd_valid_ff <= 1'b1;
                rd_err_ff   <= rd_err;
            end else if (cb_mosi_i.rd_ready) begin
                rd_valid_ff <= 1'b0;
            end

            // A handshaked element consumed by this cycle's commit bypasses its buffer.
            aw_full_ff <= ~commit & (aw_full_ff | aw_hs);
            w_full_ff  <= ~commit & (w_full_ff | w_hs);
            if (aw_hs && !commit) wbuf_ff.addr <= cb_mosi_i.wr_addr;
            if (w_hs && !commit) begin
                wbuf_ff.data   <= cb_mosi_i.wr_data;
                wbuf_ff.strobe <= cb_mosi_i.wr_strobe;
            end

            wr_resp_valid_ff <= commit | (wr_resp_valid_ff & ~cb_mosi_i.wr_resp_ready);
            if (commit) wr_resp_err_ff <= wr_err ? CB_SLVERR : CB_OKAY;
        end
    end

    cb_mem_array #(
        .MEM_WORDS (MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .re    (rd_hs),
        .ridx  (rd_off[2 +: IDX_W]),
        .rdata (arr_rdata),
        .we    (we),
        .widx  (wr_off[2 +: IDX_W]),
        .wdata (cur_data),
        .wstrb (cur_strb)
    );

    always_comb begin
        cb_miso_o               = '0;
        cb_miso_o.rd_addr_ready = rd_addr_ready;
        cb_miso_o.rd_valid      = rd_valid_ff;
        cb_miso_o.rd_data       = rd_err_ff ? 32'h0 : arr_rdata;
        cb_miso_o.rd_resp       = rd_err_ff ? CB_SLVERR : CB_OKAY;
        cb_miso_o.wr_addr_ready = ~aw_full_ff;
        cb_miso_o.wr_data_ready = ~w_full_ff;
        cb_miso_o.wr_resp_valid = wr_resp_valid_ff;
        cb_miso_o.wr_resp_error = wr_resp_err_ff;
    end

endmodule

// File: tb/tb_cb_mem_slave.sv
// Self-checking bench for cb_mem_slave: directed scenarios plus random traffic
// against a queue-based transaction model.
module tb_cb_mem_slave;
    import utils_pkg::*;

    localparam int unsigned MW   = 16;
    localparam logic [31:0] BASE = 32'h0;
`ifdef CB_MEM_ADDR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    s_cb_mosi_t mosi;
    s_cb_miso_t miso;
    int         checks = 0;
    int         failures = 0;

    cb_mem_slave #(
        .MEM_WORDS (MW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cb_mosi_i (mosi),
        .cb_miso_o (miso)
    );

    always #5 clk = ~clk;

    // Transaction-level model
    logic [31:0] m_mem [MW];
    bit          m_known [MW];
    bit          m_rd_valid, m_rd_known, m_rd_err;
    logic [31:0] m_rd_data;
    logic [31:0] aw_q [$];
    logic [35:0] w_q [$];
    bit          resp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit oob(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return ERR_EN && (off >= 32'(4 * MW));
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % MW);
    endfunction

    task automatic model_reset();
        m_rd_valid = 0;
        m_rd_data  = '0;
        m_rd_known = 1;
        m_rd_err   = 0;
        aw_q.delete();
        w_q.delete();
        resp_q.delete();
    endtask

    task automatic model_step();
        bit          rd_hs, slot, err;
        logic [31:0] a, d;
        logic [35:0] e;
        int          i;
        rd_hs = mosi.rd_addr_valid && (!m_rd_valid || mosi.rd_ready);
        if (mosi.wr_addr_valid && aw_q.size() == 0) aw_q.push_back(mosi.wr_addr);
        if (mosi.wr_data_valid && w_q.size() == 0) w_q.push_back({mosi.wr_strobe, mosi.wr_data});
        if (resp_q.size() != 0 && mosi.wr_resp_ready) begin
            void'(resp_q.pop_front());
            slot = 1;
        end else begin
            slot = (resp_q.size() == 0);
        end
        if (aw_q.size() != 0 && w_q.size() != 0 && slot) begin
            a   = aw_q.pop_front();
            e   = w_q.pop_front();
            d   = e[31:0];
            err = oob(a);
            if (!err) begin
                i = widx(a);
                for (int b = 0; b < 4; b++) if (e[32+b]) m_mem[i][8*b +: 8] = d[8*b +: 8];
                if (e[35:32] == 4'hF) m_known[i] = 1;
            end
            resp_q.push_back(err);
        end
        if (rd_hs) begin
            m_rd_valid = 1;
            m_rd_err   = oob(mosi.rd_addr);
            if (m_rd_err) begin
                m_rd_data  = '0;
                m_rd_known = 1;
            end else begin
                m_rd_data  = m_mem[widx(mosi.rd_addr)];
                m_rd_known = m_known[widx(mosi.rd_addr)];
            end
        end else if (mosi.rd_ready) begin
            m_rd_valid = 0;
        end
    endtask

    // Compare on the falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin
        if (rst) model_reset();
        check("rd_addr_ready", 32'(miso.rd_addr_ready), 32'(!m_rd_valid || mosi.rd_ready));
        check("wr_addr_ready", 32'(miso.wr_addr_ready), 32'(aw_q.size() == 0));
        check("wr_data_ready", 32'(miso.wr_data_ready), 32'(w_q.size() == 0));
        check("rd_valid", 32'(miso.rd_valid), 32'(m_rd_valid));
        check("rd_resp", 32'(miso.rd_resp), m_rd_err ? 32'(CB_SLVERR) : 32'(CB_OKAY));
        if (m_rd_known) check("rd_data", miso.rd_data, m_rd_data);
        check("wr_resp_valid", 32'(miso.wr_resp_valid), 32'(resp_q.size() != 0));
        if (resp_q.size() != 0)
            check("wr_resp_error", 32'(miso.wr_resp_error),
                  resp_q[0] ? 32'(CB_SLVERR) : 32'(CB_OKAY));
        if (!rst) model_step();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return BASE + 32'(4 * $urandom_range(0, MW + 3)) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        mosi = '0;
        repeat (2) step();
        rst = 1'b0;
        mosi.rd_ready = 1'b1;
        step();
        check("idle_rd_addr_ready", 32'(miso.rd_addr_ready), 32'd1);
        check("idle_wr_addr_ready", 32'(miso.wr_addr_ready), 32'd1);
        check("idle_wr_data_ready", 32'(miso.wr_data_ready), 32'd1);
        check("idle_rd_valid", 32'(miso.rd_valid), 32'd0);
        check("idle_wr_resp_valid", 32'(miso.wr_resp_valid), 32'd0);
        check("idle_rd_data", miso.rd_data, 32'h0);

        // Reset while the address buffer is full drops the pending write.
        mosi.wr_addr_valid = 1'b1; mosi.wr_addr = 32'h8;
        step();
        mosi.wr_addr_valid = 1'b0;
        check("aw_full_ready", 32'(miso.wr_addr_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rst_wr_addr_ready", 32'(miso.wr_addr_ready), 32'd1);
        check("rst_no_resp", 32'(miso.wr_resp_valid), 32'd0);
        mosi.wr_data_valid = 1'b1; mosi.wr_data = 32'h5555_5555; mosi.wr_strobe = 4'hF;
        step();
        mosi.wr_data_valid = 1'b0;
        step();
        check("rst_stale_addr_no_resp", 32'(miso.wr_resp_valid), 32'd0);
        mosi.wr_addr_valid = 1'b1; mosi.wr_addr = 32'h8; mosi.wr_resp_ready = 1'b1;
        step();
        mosi.wr_addr_valid = 1'b0;
        check("late_addr_resp", 32'(miso.wr_resp_valid), 32'd1);
        step();

        // Address then data on the next cycle.
        mosi.wr_resp_ready = 1'b0;
        mosi.wr_addr_valid = 1'b1; mosi.wr_addr = 32'h10;
        step();
        mosi.wr_addr_valid = 1'b0;
        check("aw_then_w_addr_ready", 32'(miso.wr_addr_ready), 32'd0);
        mosi.wr_data_valid = 1'b1; mosi.wr_data = 32'hDEAD_BEEF; mosi.wr_strobe = 4'hF;
        step();
        mosi.wr_data_valid = 1'b0;
        check("deadbeef_resp_valid", 32'(miso.wr_resp_valid), 32'd1);
        check("deadbeef_resp_okay", 32'(miso.wr_resp_error), 32'(CB_OKAY));
        check("deadbeef_addr_ready_back", 32'(miso.wr_addr_ready), 32'd1);
        mosi.wr_resp_ready = 1'b1;
        mosi.rd_addr_valid = 1'b1; mosi.rd_addr = 32'h10;
        step();
        mosi.rd_addr_valid = 1'b0;
        check("deadbeef_rd_valid", 32'(miso.rd_valid), 32'd1);
        check("deadbeef_rd_data", miso.rd_data, 32'hDEAD_BEEF);
        check("deadbeef_resp_taken", 32'(miso.wr_resp_valid), 32'd0);

        // Single-byte strobe, address and data together.
        mosi.wr_addr_valid = 1'b1; mosi.wr_addr = 32'h10;
        mosi.wr_data_valid = 1'b1; mosi.wr_data = 32'h00AA_0000; mosi.wr_strobe = 4'b0100;
        step();
        mosi.wr_addr_valid = 1'b0; mosi.wr_data_valid = 1'b0;
        check("strobe_resp_valid", 32'(miso.wr_resp_valid), 32'd1);
        mosi.rd_addr_valid = 1'b1; mosi.rd_addr = 32'h10;
        step();
        mosi.rd_addr_valid = 1'b0;
        check("strobe_rd_data", miso.rd_data, 32'hDEAA_BEEF);

        // Read of the word committed on the same edge sees the merged value.
        mosi.wr_addr_valid = 1'b1; mosi.wr_addr = 32'h10;
        mosi.wr_data_valid = 1'b1; mosi.wr_data = 32'h0000_0011; mosi.wr_strobe = 4'b0001;
        mosi.rd_addr_valid = 1'b1; mosi.rd_addr = 32'h12;
        step();
        mosi.wr_addr_valid = 1'b0; mosi.wr_data_valid = 1'b0; mosi.rd_addr_valid = 1'b0;
        check("fwd_rd_data", miso.rd_data, 32'hDEAA_BE11);
        step();

        // Data three cycles ahead of its address.
        mosi.wr_data_valid = 1'b1; mosi.wr_data = 32'h0102_0304; mosi.wr_strobe = 4'hF;
        step();
        mosi.wr_data_valid = 1'b0;
        check("w_first_data_ready", 32'(miso.wr_data_ready), 32'd0);
        step();
        step();
        check("w_first_no_resp", 32'(miso.wr_resp_valid), 32'd0);
        mosi.wr_addr_valid = 1'b1; mosi.wr_addr = 32'h14;
        step();
        mosi.wr_addr_valid = 1'b0;
        check("w_first_resp", 32'(miso.wr_resp_valid), 32'd1);
        check("w_first_data_ready_back", 32'(miso.wr_data_ready), 32'd1);
        mosi.rd_addr_valid = 1'b1; mosi.rd_addr = 32'h14;
        step();
        mosi.rd_addr_valid = 1'b0;
        check("w_first_single_resp", 32'(miso.wr_resp_valid), 32'd0);
        check("w_first_rd_data", miso.rd_data, 32'h0102_0304);

        // Two writes while the response is not taken.
        mosi.wr_resp_ready = 1'b0;
        mosi.wr_addr_valid = 1'b1; mosi.wr_addr = 32'h20;
        mosi.wr_data_valid = 1'b1; mosi.wr_data = 32'h1111_1111; mosi.wr_strobe = 4'hF;
        step();
        mosi.wr_addr = 32'h24; mosi.wr_data = 32'h2222_2222;
        step();
        mosi.wr_addr_valid = 1'b0; mosi.wr_data_valid = 1'b0;
        repeat (3) step();
        check("bp_addr_ready_low", 32'(miso.wr_addr_ready), 32'd0);
        check("bp_data_ready_low", 32'(miso.wr_data_ready), 32'd0);
        check("bp_resp_held", 32'(miso.wr_resp_valid), 32'd1);
        mosi.wr_resp_ready = 1'b1;
        step();
        check("bp_second_resp", 32'(miso.wr_resp_valid), 32'd1);
        check("bp_addr_ready_back", 32'(miso.wr_addr_ready), 32'd1);
        step();
        check("bp_drained", 32'(miso.wr_resp_valid), 32'd0);
        mosi.rd_addr_valid = 1'b1; mosi.rd_addr = 32'h20;
        step();
        check("bp_rd_first", miso.rd_data, 32'h1111_1111);
        mosi.rd_addr = 32'h24;
        step();
        mosi.rd_addr_valid = 1'b0;
        check("bp_rd_second", miso.rd_data, 32'h2222_2222);

        // One past the window: error with the feature, alias of word 0 without.
        mosi.wr_addr_valid = 1'b1; mosi.wr_addr = 32'h0;
        mosi.wr_data_valid = 1'b1; mosi.wr_data = 32'hCAFE_F00D; mosi.wr_strobe = 4'hF;
        step();
        mosi.wr_addr_valid = 1'b0; mosi.wr_data_valid = 1'b0;
        step();
        mosi.rd_addr_valid = 1'b1; mosi.rd_addr = BASE + 32'(4 * MW);
        step();
        mosi.rd_addr_valid = 1'b0;
        check("edge_rd_data", miso.rd_data, ERR_EN ? 32'h0 : 32'hCAFE_F00D);
        check("edge_rd_resp", 32'(miso.rd_resp), ERR_EN ? 32'(CB_SLVERR) : 32'(CB_OKAY));

        // Fill every word so random reads are fully predictable.
        for (int i = 0; i < int'(MW); i++) begin
            mosi.wr_addr_valid = 1'b1; mosi.wr_addr = BASE + 32'(4 * i);
            mosi.wr_data_valid = 1'b1; mosi.wr_data = $urandom; mosi.wr_strobe = 4'hF;
            step();
        end
        mosi.wr_addr_valid = 1'b0; mosi.wr_data_valid = 1'b0;
        step();

        for (int n = 0; n < 3000; n++) begin
            mosi.rd_addr_valid = 1'($urandom_range(0, 1));
            mosi.rd_addr       = rand_addr();
            mosi.rd_size       = 2'($urandom_range(0, 3));
            mosi.rd_ready      = ($urandom_range(0, 3) != 0);
            mosi.wr_addr_valid = 1'($urandom_range(0, 1));
            mosi.wr_addr       = rand_addr();
            mosi.wr_size       = 2'($urandom_range(0, 3));
            mosi.wr_data_valid = 1'($urandom_range(0, 1));
            mosi.wr_data       = $urandom;
            mosi.wr_strobe     = 4'($urandom_range(0, 15));
            mosi.wr_resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        mosi = '0;
        mosi.rd_ready = 1'b1;
        mosi.wr_resp_ready = 1'b1;
        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
